// File: rtl/char_motion_ctrl_if.sv
// Bus between the key decoder / collision logic (master) and the player
// sprite motion controller (slave): level inputs in, sprite state out.
interface char_motion_ctrl_if #(
    parameter int XW = 11
);
    logic          startOfFrame;
    logic          leftPress;
    logic          rightPress;
    logic          leftCrash;
    logic          rightCrash;
    logic          shootReq;
    logic          hit;

    logic [XW-1:0] topLeftX;
    logic [XW-1:0] topLeftY;
    logic          facingLeft;
    logic          moving;
    logic          shootFire;
    logic          stunned;
    logic [3:0]    speed;

    modport master (
        output startOfFrame, leftPress, rightPress, leftCrash, rightCrash,
               shootReq, hit,
        input  topLeftX, topLeftY, facingLeft, moving, shootFire, stunned,
               speed
    );

    modport slave (
        input  startOfFrame, leftPress, rightPress, leftCrash, rightCrash,
               shootReq, hit,
        output topLeftX, topLeftY, facingLeft, moving, shootFire, stunned,
               speed
    );
endinterface

// File: rtl/char_motion_ctrl.sv
// Player sprite motion controller. Evaluates one frame per startOfFrame
// strobe: walking with a speed ramp inside the playfield, plus freeze
// states after a shot (SHOOT) and after being hit (STUN).
module char_motion_ctrl #(
    parameter int XW           = 11,
    parameter int CHAR_WIDTH   = 32,
    parameter int CHAR_HIGHT   = 32,
    parameter int INITIAL_X    = 320,
    parameter int LEFT_BOUND   = 0,
    parameter int RIGHT_BOUND  = 640,
    parameter int FLOOR_Y      = 480,
    parameter int MIN_SPEED    = 1,
    parameter int MAX_SPEED    = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int SHOOT_FRAMES = 6,
    parameter int STUN_FRAMES  = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    char_motion_ctrl_if.slave    bus
);

    // Shared freeze counter must hold the longer of the two reload values.
    localparam int FMAX = (STUN_FRAMES > SHOOT_FRAMES) ? STUN_FRAMES : SHOOT_FRAMES;
    localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;
    localparam int AW   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [XW:0]   X_HI       = (XW+1)'(RIGHT_BOUND - CHAR_WIDTH);
    localparam logic [XW:0]   X_LO       = (XW+1)'(LEFT_BOUND);
    localparam logic [XW-1:0] X_INIT     = XW'(INITIAL_X);
    localparam logic [XW-1:0] Y_CONST    = XW'(FLOOR_Y - CHAR_HIGHT);
    localparam logic [3:0]    SPD_MIN    = 4'(MIN_SPEED);
    localparam logic [3:0]    SPD_MAX    = 4'(MAX_SPEED);
    localparam logic [FW-1:0] SHOOT_LOAD = FW'(SHOOT_FRAMES - 1);
    localparam logic [FW-1:0] STUN_LOAD  = FW'(STUN_FRAMES - 1);
    localparam logic [AW-1:0] ACC_TOP    = AW'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_WALK,
        ST_SHOOT,
        ST_STUN
    } state_t;

    state_t        r_state,       w_state;
    logic [XW-1:0] r_x,           w_x;
    logic          r_facing_left, w_facing_left;
    logic          r_moving,      w_moving;
    logic          r_shoot_fire,  w_shoot_fire;
    logic [3:0]    r_speed,       w_speed;
    logic [FW-1:0] r_fcnt,        w_fcnt;
    logic [AW-1:0] r_acnt,        w_acnt;

    logic [XW:0]   w_speed_ext;
    logic [XW:0]   w_sum;
    logic [XW:0]   w_diff;
    logic [XW:0]   w_right_x;
    logic [XW:0]   w_left_x;
    logic [3:0]    w_speed_up;
    logic          w_req_right;
    logic          w_req_left;
    logic          w_move_right;
    logic          w_move_left;
    logic          w_reversal;

    // Candidate positions use one extra bit so neither sum nor difference wraps.
    assign w_speed_ext = (XW+1)'(r_speed);
    assign w_sum       = {1'b0, r_x} + w_speed_ext;
    assign w_diff      = {1'b0, r_x} - w_speed_ext;
    assign w_right_x   = (w_sum > X_HI) ? X_HI : w_sum;
    assign w_left_x    = (w_diff[XW] || (w_diff < X_LO)) ? X_LO : w_diff;

    assign w_req_right = bus.rightPress & ~bus.leftPress  & ~bus.rightCrash;
    assign w_req_left  = bus.leftPress  & ~bus.rightPress & ~bus.leftCrash;

    // A request that clamps to the current position is not a move.
    assign w_move_right = w_req_right && (w_right_x != {1'b0, r_x});
    assign w_move_left  = w_req_left  && (w_left_x  != {1'b0, r_x});

    // The previous frame moved the other way: this frame is a reversal.
    assign w_reversal  = r_moving && (r_facing_left != w_move_left);
    assign w_speed_up  = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 4'd1;

    // Frame evaluation: freeze handling in priority order, then the move rule.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state       = r_state;
        w_x           = r_x;
        w_facing_left = r_facing_left;
        w_moving      = r_moving;
        w_shoot_fire  = 1'b0;
        w_speed       = r_speed;
        w_fcnt        = r_fcnt;
        w_acnt        = r_acnt;

        if (bus.startOfFrame) begin
            // Any frame without an actual move ends with the ramp reset.
            w_moving = 1'b0;
            w_speed  = SPD_MIN;
            w_acnt   = '0;

            if (r_state == ST_STUN) begin
                // Hits and shots are ignored so the stun cannot be extended.
                if (r_fcnt == '0) begin
                    w_state = ST_WALK;
                end else begin
                    w_fcnt = r_fcnt - FW'(1);
                end
            end else if (bus.hit) begin
                w_state = ST_STUN;
                w_fcnt  = STUN_LOAD;
            end else if (r_state == ST_SHOOT) begin
                if (r_fcnt == '0) begin
                    w_state = ST_WALK;
                end else begin
                    w_fcnt = r_fcnt - FW'(1);
                end
            end else if (bus.shootReq) begin
                w_state      = ST_SHOOT;
                w_fcnt       = SHOOT_LOAD;
                w_shoot_fire = 1'b1;
            end else if (w_move_right || w_move_left) begin
                w_x           = w_move_left ? w_left_x[XW-1:0] : w_right_x[XW-1:0];
                w_moving      = 1'b1;
                w_facing_left = w_move_left;
                // A reversal keeps the MIN_SPEED / zero-count defaults above.
                if (!w_reversal) begin
                    if (r_acnt == ACC_TOP) begin
                        w_speed = w_speed_up;
                        w_acnt  = '0;
                    end else begin
                        w_speed = r_speed;
                        w_acnt  = r_acnt + AW'(1);
                    end
                end
            end
        end
    end

    // State and position registers; reset returns the sprite to its start pose.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_WALK;
            r_x           <= X_INIT;
            r_facing_left <= 1'b0;
            r_moving      <= 1'b0;
            r_shoot_fire  <= 1'b0;
            r_speed       <= SPD_MIN;
            r_fcnt        <= '0;
            r_acnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            r_state       <= w_state;
            r_x           <= w_x;
            r_facing_left <= w_facing_left;
            r_moving      <= w_moving;
            r_shoot_fire  <= w_shoot_fire;
            r_speed       <= w_speed;
            r_fcnt        <= w_fcnt;
            r_acnt        <= w_acnt;
        end
    end

    assign bus.topLeftX   = r_x;
    assign bus.topLeftY   = Y_CONST;
    assign bus.facingLeft = r_facing_left;
    assign bus.moving     = r_moving;
    assign bus.shootFire  = r_shoot_fire;
    assign bus.stunned    = (r_state == ST_STUN);
    assign bus.speed      = r_speed;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Self-checking bench for char_motion_ctrl: directed scenarios followed by
// random frames, all compared against a frame-level behavioural model.
module tb_char_motion_ctrl;

    localparam int XW           = 11;
    localparam int CHAR_WIDTH   = 32;
    localparam int CHAR_HIGHT   = 32;
    localparam int INITIAL_X    = 320;
    localparam int LEFT_BOUND   = 0;
    localparam int RIGHT_BOUND  = 640;
    localparam int FLOOR_Y      = 480;
    localparam int MIN_SPEED    = 1;
    localparam int MAX_SPEED    = 4;
    localparam int ACCEL_FRAMES = 8;
    localparam int SHOOT_FRAMES = 6;
    localparam int STUN_FRAMES  = 60;

    logic clk    = 1'b0;
    logic resetN = 1'b1;

    char_motion_ctrl_if #(.XW(XW)) bus ();

    char_motion_ctrl #(
        .XW(XW), .CHAR_WIDTH(CHAR_WIDTH), .CHAR_HIGHT(CHAR_HIGHT),
        .INITIAL_X(INITIAL_X), .LEFT_BOUND(LEFT_BOUND), .RIGHT_BOUND(RIGHT_BOUND),
        .FLOOR_Y(FLOOR_Y), .MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED),
        .ACCEL_FRAMES(ACCEL_FRAMES), .SHOOT_FRAMES(SHOOT_FRAMES),
        .STUN_FRAMES(STUN_FRAMES)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: remaining freeze frames, length of the current
    // same-direction run, and the direction moved in the last frame.
    int m_x, m_speed, m_run, m_last_dir, m_stun_left, m_shoot_left;
    bit m_facing_left, m_moving, m_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = INITIAL_X; m_speed = MIN_SPEED; m_run = 0; m_last_dir = 0;
        m_stun_left = 0; m_shoot_left = 0;
        m_facing_left = 1'b0; m_moving = 1'b0; m_fire = 1'b0;
    endtask

    task automatic model_freeze();
        m_moving = 1'b0; m_run = 0; m_speed = MIN_SPEED; m_last_dir = 0;
    endtask

    task automatic model_frame();
        int dir;
        int target;
        m_fire = 1'b0;
        if (m_stun_left > 0) begin
            m_stun_left--;
            model_freeze();
        end else if (bus.hit) begin
            m_stun_left  = STUN_FRAMES;
            m_shoot_left = 0;
            model_freeze();
        end else if (m_shoot_left > 0) begin
            m_shoot_left--;
            model_freeze();
        end else if (bus.shootReq) begin
            m_shoot_left = SHOOT_FRAMES;
            m_fire       = 1'b1;
            model_freeze();
        end else begin
            dir = 0;
            if (bus.rightPress && !bus.leftPress && !bus.rightCrash) dir = 1;
            else if (bus.leftPress && !bus.rightPress && !bus.leftCrash) dir = -1;
            target = m_x + dir * m_speed;
            if (target > RIGHT_BOUND - CHAR_WIDTH) target = RIGHT_BOUND - CHAR_WIDTH;
            if (target < LEFT_BOUND) target = LEFT_BOUND;
            if (dir != 0 && target != m_x) begin
                if (m_last_dir == -dir) begin
                    m_run   = 0;
                    m_speed = MIN_SPEED;
                end else begin
                    m_run++;
                    m_speed = MIN_SPEED + m_run / ACCEL_FRAMES;
                    if (m_speed > MAX_SPEED) m_speed = MAX_SPEED;
                end
                m_x           = target;
                m_facing_left = (dir < 0);
                m_moving      = 1'b1;
                m_last_dir    = dir;
            end else begin
                model_freeze();
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x"},       bus.topLeftX,   m_x);
        check({tag, ".y"},       bus.topLeftY,   FLOOR_Y - CHAR_HIGHT);
        check({tag, ".facing"},  bus.facingLeft, m_facing_left);
        check({tag, ".moving"},  bus.moving,     m_moving);
        check({tag, ".fire"},    bus.shootFire,  m_fire);
        check({tag, ".stunned"}, bus.stunned,    (m_stun_left > 0));
        check({tag, ".speed"},   bus.speed,      m_speed);
    endtask

    task automatic set_in(input bit lp, input bit rp, input bit lc, input bit rc,
                          input bit sr, input bit h);
        bus.leftPress = lp; bus.rightPress = rp; bus.leftCrash = lc;
        bus.rightCrash = rc; bus.shootReq = sr; bus.hit = h;
    endtask

    // One frame strobe from a negedge, then one idle clock where only the
    // shootFire pulse may change.
    task automatic run_frame(input bit lp, input bit rp, input bit lc, input bit rc,
                             input bit sr, input bit h);
        set_in(lp, rp, lc, rc, sr, h);
        bus.startOfFrame = 1'b1;
        @(posedge clk);
        model_frame();
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        check_all("frame");
        @(posedge clk);
        @(negedge clk);
        m_fire = 1'b0;
        check_all("idle");
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int stun_seen;
        int x_hold;

        model_reset();
        set_in(0, 0, 0, 0, 0, 0);
        bus.startOfFrame = 1'b0;
        #1 resetN = 1'b0;
        @(negedge clk);
        check_all("por");
        @(negedge clk);
        resetN = 1'b1;

        // Speed ramp from rest while holding right.
        for (int i = 1; i <= 24; i++) begin
            run_frame(0, 1, 0, 0, 0, 0);
            if (i == 8)  check("ramp8_x",  bus.topLeftX, 328);
            if (i == 16) check("ramp16_x", bus.topLeftX, 344);
            if (i == 24) begin
                check("ramp24_x",     bus.topLeftX, 368);
                check("ramp24_speed", bus.speed,    4);
            end
        end

        // Run into the right bound at full speed.
        for (int i = 0; i < 58; i++) run_frame(0, 1, 0, 0, 0, 0);
        check("pre_bound_x", bus.topLeftX, 600);
        run_frame(0, 1, 0, 0, 0, 0);
        check("bound_604", bus.topLeftX, 604);
        run_frame(0, 1, 0, 0, 0, 0);
        check("bound_608", bus.topLeftX, 608);
        run_frame(0, 1, 0, 0, 0, 0);
        check("bound_hold_x",      bus.topLeftX, 608);
        check("bound_hold_moving", bus.moving,   0);
        check("bound_hold_speed",  bus.speed,    MIN_SPEED);

        // Both keys together, then right held against a wall.
        run_frame(1, 1, 0, 0, 0, 0);
        check("both_keys_x",      bus.topLeftX, 608);
        check("both_keys_moving", bus.moving,   0);
        for (int i = 0; i < 10; i++) run_frame(1, 0, 0, 0, 0, 0);
        x_hold = m_x;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 1, 0, 1, 0, 0);
            check("crash_x",      bus.topLeftX, x_hold);
            check("crash_moving", bus.moving,   0);
        end

        // Reversal after a ramped left run.
        for (int i = 0; i < 12; i++) run_frame(1, 0, 0, 0, 0, 0);
        run_frame(0, 1, 0, 0, 0, 0);
        check("reversal_moving", bus.moving, 1);
        check("reversal_speed",  bus.speed,  MIN_SPEED);

        // Shot from X=320 with right held; shootReq held during the freeze.
        pulse_reset();
        run_frame(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < SHOOT_FRAMES; i++) begin
            run_frame(0, 1, 0, 0, 1, 0);
            check("shoot_frozen_x", bus.topLeftX, 320);
        end
        run_frame(0, 1, 0, 0, 0, 0);
        check("shoot_resume_x",     bus.topLeftX, 321);
        check("shoot_resume_speed", bus.speed,    MIN_SPEED);

        // Hit during SHOOT; a second hit and shot requests are ignored.
        run_frame(0, 0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 1);
        stun_seen = bus.stunned ? 1 : 0;
        for (int k = 1; k <= STUN_FRAMES; k++) begin
            run_frame(0, 1, 0, 0, 1, (k == 30));
            if (bus.stunned) stun_seen++;
        end
        check("stun_length", stun_seen, STUN_FRAMES);
        check("stun_done",   bus.stunned, 0);

        // Reset in the middle of a stun with X=400.
        pulse_reset();
        for (int i = 0; i < 32; i++) run_frame(0, 1, 0, 0, 0, 0);
        check("pre_stun_x", bus.topLeftX, 400);
        run_frame(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) run_frame(0, 0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        model_reset();
        #1;
        check_all("midstun_reset");
        check("midstun_reset_x",       bus.topLeftX, 320);
        check("midstun_reset_stunned", bus.stunned,  0);
        @(negedge clk);
        resetN = 1'b1;
        run_frame(0, 1, 0, 0, 0, 0);
        check("post_reset_walk_x", bus.topLeftX, 321);

        // startOfFrame held high: one frame per clock, shootFire only once.
        set_in(0, 1, 0, 0, 1, 0);
        bus.startOfFrame = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            model_frame();
            @(negedge clk);
            check_all("burst");
        end
        bus.startOfFrame = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_fire = 1'b0;
        check_all("burst_idle");

        // Random frames.
        for (int i = 0; i < 400; i++) begin
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
